// File: rtl/kbd_pkg.sv
// Shared constants, state encoding and frame-unpacking helper for the keyboard SPI matrix receiver.
package kbd_pkg;

    localparam int FRAME_BITS = 48;
    localparam int ROWS       = 8;
    localparam int COLS       = 5;

    localparam int ST_MAGIC = 0;
    localparam int ST_TURBO = 1;
    localparam int ST_PNT   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    typedef logic [ROWS-1:0][COLS-1:0] matrix_t;

    // Row 0 arrives first with col4 leading, so row r sits at the top of the remaining bits.
    function automatic matrix_t frame_to_matrix(input logic [ROWS*COLS-1:0] bits);
        matrix_t m;
        for (int r = 0; r < ROWS; r++) begin
            m[r] = bits[ROWS*COLS-1-COLS*r -: COLS];
        end
        return m;
    endfunction

endpackage

// File: rtl/kbd_sync_edge.sv
// Multi-flop synchroniser with rising/falling edge strobes for one asynchronous input.
module kbd_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLK_14MHZ,
    input  logic CPU_RESET,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic [STAGES:0]   live;
    logic              level;

    // Edges are only reported once both the chain and prev hold genuine pin samples, so the
    // step from the reset value to a low pin after reset is not mistaken for an edge.
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            live  <= '0;
        end else begin
            chain[0] <= pin;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= level;
            live <= {live[STAGES-1:0], 1'b1};
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = live[STAGES] &  level & ~prev;
    assign fall  = live[STAGES] & ~level &  prev;

endmodule

// File: rtl/kbd_spi_matrix.sv
// SPI slave holding the ZX 8x5 keyboard matrix and status byte; KD feeds the port #FE read path.
// Optional watchdog release of the matrix is enabled by defining KBD_TIMEOUT_EN.
module kbd_spi_matrix
    import kbd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef KBD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1400000
`endif
) (
    input  logic       CLK_14MHZ,
    input  logic       CPU_RESET,
    input  logic       KBD_CLK,
    input  logic       KBD_CS,
    input  logic       KBD_DI,
    input  logic [7:0] A_HI,
    output logic [4:0] KD,
    output logic [7:0] KBD_STATUS,
    output logic       FRAME_OK,
    output logic       FRAME_ERR,
    output logic       LINK_UP
);

    localparam logic [5:0] FULL_COUNT = 6'(FRAME_BITS);
    localparam logic [5:0] SAT_COUNT  = 6'd63;

    logic clk_rise;
    logic clk_fall;
    logic cs_rise;
    logic cs_fall;
    logic di;

    logic [SYNC_STAGES-1:0] di_chain;

    state_t state_q;
    state_t state_d;

    logic                  start_frame;
    logic                  shift_en;
    logic                  commit;
    logic                  discard;
    logic                  timeout;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [5:0]            bit_cnt;
    matrix_t               matrix;
    logic [COLS-1:0]       pressed;

    kbd_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) clk_sync (
        .CLK_14MHZ (CLK_14MHZ),
        .CPU_RESET (CPU_RESET),
        .pin       (KBD_CLK),
        .rise      (clk_rise),
        .fall      (clk_fall)
    );

    kbd_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) cs_sync (
        .CLK_14MHZ (CLK_14MHZ),
        .CPU_RESET (CPU_RESET),
        .pin       (KBD_CS),
        .rise      (cs_rise),
        .fall      (cs_fall)
    );

    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            di_chain <= '0;
        end else begin
            di_chain[0] <= KBD_DI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                di_chain[i] <= di_chain[i-1];
            end
        end
    end

    assign di = di_chain[SYNC_STAGES-1];

    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A clock edge coinciding with the CS rising edge is dropped so a bad length stays bad.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        commit      = 1'b0;
        discard     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    start_frame = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = CHECK;
                end else if (clk_rise) begin
                    shift_en = 1'b1;
                end
            end
            CHECK: begin
                if (bit_cnt == FULL_COUNT) begin
                    commit = 1'b1;
                end else begin
                    discard = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            matrix     <= '0;
            KBD_STATUS <= '0;
            FRAME_OK   <= 1'b0;
            FRAME_ERR  <= 1'b0;
            LINK_UP    <= 1'b0;
        end else begin
            FRAME_OK  <= commit;
            FRAME_ERR <= discard;
            if (start_frame) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], di};
                if (bit_cnt != SAT_COUNT) begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end
            if (commit) begin
                matrix     <= frame_to_matrix(shift_reg[FRAME_BITS-1:8]);
                KBD_STATUS <= shift_reg[7:0];
                LINK_UP    <= 1'b1;
            end else if (timeout) begin
                matrix     <= '0;
                KBD_STATUS <= '0;
                LINK_UP    <= 1'b0;
            end
        end
    end

`ifdef KBD_TIMEOUT_EN
    localparam int                WD_BITS  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(TIMEOUT_CYCLES - 1);

    logic [WD_BITS-1:0] wd_cnt;

    // Saturates at the limit, so a silent link keeps the keys released until the next frame.
    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            wd_cnt <= '0;
        end else if (commit) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_LIMIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout = (wd_cnt == WD_LIMIT);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        pressed = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!A_HI[r]) begin
                pressed = pressed | matrix[r];
            end
        end
        KD = ~pressed;
    end

endmodule

// File: tb/tb_kbd_spi_matrix.sv
// Self-checking bench for kbd_spi_matrix: frame scoreboard plus a reference key-matrix model.
module tb_kbd_spi_matrix;
    import kbd_pkg::*;

    localparam int HALF = 8;

    logic       clk_14mhz;
    logic       cpu_reset;
    logic       kbd_clk;
    logic       kbd_cs;
    logic       kbd_di;
    logic [7:0] a_hi;
    logic [4:0] kd;
    logic [7:0] kbd_status;
    logic       frame_ok;
    logic       frame_err;
    logic       link_up;

    int checks;
    int errors;

    bit exp_q[$];
    bit obs_q[$];

    logic [7:0][4:0] model_keys;
    logic [7:0]      model_status;
    logic            model_link;

    kbd_spi_matrix #(
        .SYNC_STAGES (2)
`ifdef KBD_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (1000)
`endif
    ) dut (
        .CLK_14MHZ  (clk_14mhz),
        .CPU_RESET  (cpu_reset),
        .KBD_CLK    (kbd_clk),
        .KBD_CS     (kbd_cs),
        .KBD_DI     (kbd_di),
        .A_HI       (a_hi),
        .KD         (kd),
        .KBD_STATUS (kbd_status),
        .FRAME_OK   (frame_ok),
        .FRAME_ERR  (frame_err),
        .LINK_UP    (link_up)
    );

    initial clk_14mhz = 1'b0;
    always #36 clk_14mhz = ~clk_14mhz;

    // Every cycle a pulse is high becomes one observed event, so stretched pulses show up.
    always @(negedge clk_14mhz) begin
        if (frame_ok)  obs_q.push_back(1'b1);
        if (frame_err) obs_q.push_back(1'b0);
    end

    initial begin
        #(72 * 200000);
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    function automatic logic [47:0] build_frame(input logic [7:0][4:0] keys, input logic [7:0] st);
        logic [47:0] f;
        f = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 5; c++) begin
                f[47 - 5*r - (4 - c)] = keys[r][c];
            end
        end
        f[7:0] = st;
        return f;
    endfunction

    function automatic logic [4:0] model_kd(input logic [7:0] sel);
        logic [4:0] acc;
        acc = '0;
        for (int r = 0; r < 8; r++) begin
            if (sel[r] == 1'b0) acc = acc | model_keys[r];
        end
        return ~acc;
    endfunction

    task automatic clock_bit(input logic b);
        kbd_clk = 1'b0;
        kbd_di  = b;
        repeat (HALF) @(negedge clk_14mhz);
        kbd_clk = 1'b1;
        repeat (HALF) @(negedge clk_14mhz);
    endtask

    // Sends the low nbits of data MSB first, then reports pulse latency and KD around it.
    task automatic send_bits(input logic [63:0] data, input int nbits, output int lat,
                             output logic [4:0] kd_prev, output logic [4:0] kd_pulse);
        @(negedge clk_14mhz);
        kbd_cs = 1'b0;
        repeat (HALF) @(negedge clk_14mhz);
        for (int i = nbits - 1; i >= 0; i--) begin
            clock_bit(data[i]);
        end
        repeat (HALF) @(negedge clk_14mhz);
        kbd_cs   = 1'b1;
        lat      = -1;
        kd_prev  = kd;
        kd_pulse = kd;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_14mhz);
            if (frame_ok || frame_err) begin
                lat      = n;
                kd_pulse = kd;
                break;
            end
            kd_prev = kd;
        end
        repeat (HALF) @(negedge clk_14mhz);
    endtask

    task automatic test_reset;
        logic [7:0] sels [3];
        sels = '{8'h00, 8'hFE, 8'hFF};
        cpu_reset = 1'b0;
        kbd_cs = 1'b1; kbd_clk = 1'b1; kbd_di = 1'b0; a_hi = 8'hFF;
        repeat (5) @(negedge clk_14mhz);
        cpu_reset = 1'b1;
        model_keys = '0; model_status = '0; model_link = 1'b0;
        repeat (100) @(negedge clk_14mhz);
        for (int i = 0; i < 3; i++) begin
            a_hi = sels[i];
            #1;
            checks++;
            if (kd !== 5'b11111) begin
                errors++;
                $display("[TB] FAIL reset_kd a_hi=%h: got %b expected 11111", a_hi, kd);
            end
        end
        checks++;
        if (link_up !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_link_up: got %b expected 0", link_up);
        end
        checks++;
        if (kbd_status !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h expected 00", kbd_status);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_pulses: got %0d events expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_valid_frame;
        int lat;
        logic [4:0] kd_prev, kd_pulse;
        bit e, o;
        model_keys = '0;
        model_keys[0][0] = 1'b1;
        model_status = 8'h00;
        model_status[ST_MAGIC] = 1'b1;
        model_status[ST_TURBO] = 1'b1;
        a_hi = 8'hFE;
        exp_q.push_back(1'b1);
        send_bits({16'h0, build_frame(model_keys, model_status)}, 48, lat, kd_prev, kd_pulse);
        model_link = 1'b1;
        checks++;
        if (lat != 4) begin
            errors++;
            $display("[TB] FAIL ok_latency: got %0d cycles expected 4", lat);
        end
        checks++;
        if (kd_prev !== 5'b11111 || kd_pulse !== 5'b11110) begin
            errors++;
            $display("[TB] FAIL kd_update_timing: got %b->%b expected 11111->11110", kd_prev, kd_pulse);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL valid_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL valid_event: got ok=%b expected ok=%b", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        a_hi = 8'h7F; #1;
        checks++;
        if (kd !== 5'b11111) begin
            errors++;
            $display("[TB] FAIL kd_row7_only: got %b expected 11111", kd);
        end
        a_hi = 8'h00; #1;
        checks++;
        if (kd !== 5'b11110) begin
            errors++;
            $display("[TB] FAIL kd_all_rows: got %b expected 11110", kd);
        end
        checks++;
        if (kbd_status !== 8'h03) begin
            errors++;
            $display("[TB] FAIL status_03: got %h expected 03", kbd_status);
        end
        checks++;
        if (link_up !== 1'b1) begin
            errors++;
            $display("[TB] FAIL link_up_after_ok: got %b expected 1", link_up);
        end
    endtask

    task automatic test_multi_row;
        int lat;
        logic [4:0] kd_prev, kd_pulse;
        logic [7:0] sel;
        bit e, o;
        model_keys = '0;
        model_keys[0][0] = 1'b1;
        model_keys[7][4] = 1'b1;
        model_status = 8'h00;
        model_status[ST_PNT] = 1'b1;
        exp_q.push_back(1'b1);
        send_bits({16'h0, build_frame(model_keys, model_status)}, 48, lat, kd_prev, kd_pulse);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL multi_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL multi_event: got ok=%b expected ok=%b", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        a_hi = 8'h7E; #1;
        checks++;
        if (kd !== 5'b01110) begin
            errors++;
            $display("[TB] FAIL kd_or_rows: got %b expected 01110", kd);
        end
        for (int r = 0; r < 8; r++) begin
            sel = 8'hFF;
            sel[r] = 1'b0;
            a_hi = sel; #1;
            checks++;
            if (kd !== model_kd(sel)) begin
                errors++;
                $display("[TB] FAIL kd_row%0d: got %b expected %b", r, kd, model_kd(sel));
            end
        end
        a_hi = 8'hFF; #1;
        checks++;
        if (kd !== 5'b11111) begin
            errors++;
            $display("[TB] FAIL kd_no_rows: got %b expected 11111", kd);
        end
        checks++;
        if (kbd_status !== model_status) begin
            errors++;
            $display("[TB] FAIL status_pnt: got %h expected %h", kbd_status, model_status);
        end
    endtask

    // Each bad frame follows a fresh valid one so the held matrix is checked within any watchdog window.
    task automatic test_bad_lengths;
        int lat;
        logic [4:0] kd_prev, kd_pulse;
        logic [47:0] good, junk;
        logic [7:0][4:0] all_keys;
        int lens [3];
        bit e, o;
        lens = '{47, 49, 0};
        all_keys = '1;
        junk = build_frame(all_keys, 8'hFF);
        model_keys = '0;
        model_keys[3][2] = 1'b1;
        model_status = 8'h05;
        good = build_frame(model_keys, model_status);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(1'b1);
            send_bits({16'h0, good}, 48, lat, kd_prev, kd_pulse);
            exp_q.push_back(1'b0);
            if (lens[k] == 47)      send_bits({16'h0, junk}, 47, lat, kd_prev, kd_pulse);
            else if (lens[k] == 49) send_bits({15'h0, junk, 1'b1}, 49, lat, kd_prev, kd_pulse);
            else                    send_bits(64'h0, 0, lat, kd_prev, kd_pulse);
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("[TB] FAIL bad%0d_event_count: got %0d expected %0d", lens[k], obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL bad%0d_event: got ok=%b expected ok=%b", lens[k], o, e);
                end
            end
            exp_q.delete(); obs_q.delete();
            a_hi = 8'h00; #1;
            checks++;
            if (kd !== model_kd(8'h00)) begin
                errors++;
                $display("[TB] FAIL bad%0d_kd_held: got %b expected %b", lens[k], kd, model_kd(8'h00));
            end
            checks++;
            if (kbd_status !== model_status) begin
                errors++;
                $display("[TB] FAIL bad%0d_status_held: got %h expected %h", lens[k], kbd_status, model_status);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int lat;
        logic [4:0] kd_prev, kd_pulse;
        logic [47:0] f;
        bit e, o;
        model_keys = '0;
        model_keys[5][1] = 1'b1;
        f = build_frame(model_keys, 8'h02);
        @(negedge clk_14mhz);
        kbd_cs = 1'b0;
        repeat (HALF) @(negedge clk_14mhz);
        for (int i = 47; i >= 28; i--) clock_bit(f[i]);
        cpu_reset = 1'b0;
        repeat (4) @(negedge clk_14mhz);
        cpu_reset = 1'b1;
        model_keys = '0; model_status = '0; model_link = 1'b0;
        obs_q.delete();
        for (int i = 27; i >= 0; i--) clock_bit(f[i]);
        repeat (HALF) @(negedge clk_14mhz);
        kbd_cs = 1'b1;
        repeat (40) @(negedge clk_14mhz);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_pulses: got %0d events expected 0", obs_q.size());
        end
        obs_q.delete();
        a_hi = 8'h00; #1;
        checks++;
        if (kd !== 5'b11111 || link_up !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_state: got kd=%b link=%b expected kd=11111 link=0", kd, link_up);
        end
        model_keys[5][1] = 1'b1;
        model_status = 8'h02;
        exp_q.push_back(1'b1);
        send_bits({16'h0, build_frame(model_keys, model_status)}, 48, lat, kd_prev, kd_pulse);
        model_link = 1'b1;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL midreset_next_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL midreset_next_event: got ok=%b expected ok=%b", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        a_hi = 8'hDF; #1;
        checks++;
        if (kd !== model_kd(8'hDF) || kbd_status !== 8'h02 || link_up !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_next_commit: got kd=%b st=%h link=%b expected kd=%b st=02 link=1",
                     kd, kbd_status, link_up, model_kd(8'hDF));
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [4:0] kd_prev, kd_pulse;
        logic [39:0] rnd;
        logic [7:0] sel;
        bit e, o;
        for (int k = 0; k < 2; k++) begin
            rnd[31:0]  = $urandom();
            rnd[39:32] = 8'($urandom());
            model_keys   = rnd;
            model_status = 8'($urandom());
            a_hi = 8'h00;
            exp_q.push_back(1'b1);
            send_bits({16'h0, build_frame(model_keys, model_status)}, 48, lat, kd_prev, kd_pulse);
            checks++;
            if (kd_pulse !== model_kd(8'h00)) begin
                errors++;
                $display("[TB] FAIL b2b%0d_kd_all: got %b expected %b", k, kd_pulse, model_kd(8'h00));
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL b2b_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL b2b_event: got ok=%b expected ok=%b", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        for (int r = 0; r < 8; r++) begin
            sel = 8'hFF;
            sel[r] = 1'b0;
            a_hi = sel; #1;
            checks++;
            if (kd !== model_kd(sel)) begin
                errors++;
                $display("[TB] FAIL b2b_row%0d: got %b expected %b", r, kd, model_kd(sel));
            end
        end
        checks++;
        if (kbd_status !== model_status) begin
            errors++;
            $display("[TB] FAIL b2b_status: got %h expected %h", kbd_status, model_status);
        end
    endtask

`ifdef KBD_TIMEOUT_EN
    task automatic test_timeout;
        int lat;
        logic [4:0] kd_prev, kd_pulse;
        bit e, o;
        model_keys = '0;
        model_keys[2][3] = 1'b1;
        model_status = 8'h01;
        a_hi = 8'h00;
        exp_q.push_back(1'b1);
        send_bits({16'h0, build_frame(model_keys, model_status)}, 48, lat, kd_prev, kd_pulse);
        repeat (980) @(negedge clk_14mhz);
        checks++;
        if (kd !== 5'b10111 || link_up !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_early: got kd=%b link=%b expected kd=10111 link=1", kd, link_up);
        end
        repeat (20) @(negedge clk_14mhz);
        checks++;
        if (kd !== 5'b11111 || link_up !== 1'b0 || kbd_status !== 8'h00) begin
            errors++;
            $display("[TB] FAIL timeout_release: got kd=%b link=%b st=%h expected kd=11111 link=0 st=00",
                     kd, link_up, kbd_status);
        end
        model_keys[2][3] = 1'b1;
        exp_q.push_back(1'b1);
        send_bits({16'h0, build_frame(model_keys, model_status)}, 48, lat, kd_prev, kd_pulse);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL timeout_event_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL timeout_event: got ok=%b expected ok=%b", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (link_up !== 1'b1 || kd !== 5'b10111) begin
            errors++;
            $display("[TB] FAIL timeout_restore: got link=%b kd=%b expected link=1 kd=10111", link_up, kd);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_valid_frame();
        test_multi_row();
        test_bad_lengths();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef KBD_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
